// File: rtl/i2c_reg_sequencer.sv
// I2C register-transaction sequencer: drives a byte-level I2C master through either a
// pointer-write + repeated-start burst read into a local buffer, or a single register write.
module i2c_reg_sequencer #(
    parameter logic [6:0] DEV_ADR    = 7'h77,
    parameter int         MAX_BYTES  = 22,
    parameter int         CNT_W      = 5,
    parameter int         START_HOLD = 15,
    parameter int         TIMEOUT    = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             rnw,
    input  logic [7:0]       reg_adr,
    input  logic [7:0]       wr_data,
    input  logic [CNT_W-1:0] rd_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [CNT_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    input  logic             isReady,
    output logic             start,
    output logic             send,
    output logic [7:0]       datasend,
    input  logic             sended,
    output logic             receive,
    input  logic [7:0]       datareceive,
    input  logic             received
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RDY = 3'd1;
    localparam logic [2:0] S_SEND     = 3'd2;
    localparam logic [2:0] S_RECV     = 3'd3;
    localparam logic [2:0] S_FIN      = 3'd4;

    localparam int                HOLD_W   = $clog2(START_HOLD + 2);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(START_HOLD);
    localparam logic [CNT_W-1:0]  MAX_LEN  = CNT_W'(MAX_BYTES);
    localparam logic [31:0]       TMO_LAST = 32'(TIMEOUT - 1);

    logic [2:0]        state;
    logic [1:0]        k;
    logic [CNT_W-1:0]  j;
    logic [CNT_W-1:0]  len_q;
    logic              rnw_q;
    logic [7:0]        reg_q;
    logic [7:0]        wdat_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [31:0]       tmo_cnt;
    logic              sended_q;
    logic              received_q;
    logic [7:0]        rx_buf [MAX_BYTES];

    logic       sended_rise;
    logic       received_rise;
    logic       tmo_hit;
    logic [7:0] cur_byte;
    logic       cur_s;

    assign sended_rise   = sended & ~sended_q;
    assign received_rise = received & ~received_q;
    assign tmo_hit       = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    // Byte list is rebuilt from the values frozen at acceptance, indexed by k.
    always_comb begin
        cur_byte = {DEV_ADR, 1'b0};
        cur_s    = 1'b1;
        case (k)
            2'd1: begin
                cur_byte = reg_q;
                cur_s    = 1'b0;
            end
            2'd2: begin
                cur_byte = rnw_q ? {DEV_ADR, 1'b1} : wdat_q;
                cur_s    = rnw_q;
            end
            default: ;
        endcase
    end

    assign send     = (state == S_SEND);
    assign receive  = (state == S_RECV);
    assign datasend = send ? cur_byte : 8'h00;
    assign start    = send && cur_s && (hold_cnt < HOLD_MAX);
    assign rd_data  = (rd_idx < MAX_LEN) ? rx_buf[rd_idx] : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            k          <= 2'd0;
            j          <= '0;
            len_q      <= '0;
            rnw_q      <= 1'b0;
            reg_q      <= 8'h00;
            wdat_q     <= 8'h00;
            hold_cnt   <= '0;
            tmo_cnt    <= '0;
            sended_q   <= 1'b0;
            received_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            // NOTE: the buffer is flop-based and cleared on reset, so it cannot map to RAM.
            for (int i = 0; i < MAX_BYTES; i++) rx_buf[i] <= 8'h00;
        end else begin
            sended_q   <= sended;
            received_q <= received;
            done       <= 1'b0;
            err        <= 1'b0;
            tmo_cnt    <= tmo_cnt + 32'd1;
            case (state)
                S_IDLE: begin
                    // A req coinciding with a done pulse is dropped.
                    if (req && !done) begin
                        if (rnw && (rd_len == '0 || rd_len > MAX_LEN)) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            rnw_q   <= rnw;
                            reg_q   <= reg_adr;
                            wdat_q  <= wr_data;
                            len_q   <= rd_len;
                            busy    <= 1'b1;
                            tmo_cnt <= '0;
                            state   <= S_WAIT_RDY;
                        end
                    end
                end
                S_WAIT_RDY: begin
                    if (isReady) begin
                        k        <= 2'd0;
                        hold_cnt <= '0;
                        tmo_cnt  <= '0;
                        state    <= S_SEND;
                    end else if (tmo_hit) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (sended_rise) begin
                        tmo_cnt  <= '0;
                        hold_cnt <= '0;
                        if (k == 2'd2) begin
                            if (rnw_q) begin
                                j     <= '0;
                                state <= S_RECV;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_FIN;
                            end
                        end else begin
                            k <= k + 2'd1;
                        end
                    end else begin
                        if (hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
                        if (tmo_hit) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                S_RECV: begin
                    if (received_rise) begin
                        rx_buf[j] <= datareceive;
                        j         <= j + CNT_W'(1);
                        tmo_cnt   <= '0;
                        if (j + CNT_W'(1) == len_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end else if (tmo_hit) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench for i2c_reg_sequencer: a behavioural I2C master answers the DUT, a
// monitor pops expected bytes/done pulses from a queue as the DUT presents them.
module tb_i2c_reg_sequencer;

    localparam int TMO = 100;

    typedef struct {
        bit         is_done;
        logic [7:0] val;
        int         st;
        bit         err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, req, rnw, isReady, sended, received;
    logic [7:0] reg_adr, wr_data, datareceive;
    logic [4:0] rd_len, rd_idx;
    logic       busy, done, err, start, send, receive;
    logic [7:0] rd_data, datasend;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_rx_cyc = 0;
    int rx_hi   = 0;
    exp_t exp_q[$];
    logic [7:0] rx_q[$];

    i2c_reg_sequencer #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .rnw(rnw), .reg_adr(reg_adr),
        .wr_data(wr_data), .rd_len(rd_len), .busy(busy), .done(done), .err(err),
        .rd_idx(rd_idx), .rd_data(rd_data), .isReady(isReady), .start(start),
        .send(send), .datasend(datasend), .sended(sended), .receive(receive),
        .datareceive(datareceive), .received(received)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic exp_byte(input logic [7:0] v, input int st);
        exp_t e;
        e.is_done = 1'b0; e.val = v; e.st = st; e.err = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input bit e_err);
        exp_t e;
        e.is_done = 1'b1; e.val = 8'h00; e.st = 0; e.err = e_err;
        exp_q.push_back(e);
    endtask

    task automatic do_req(input logic r, input logic [7:0] ra, input logic [7:0] wd,
                          input logic [4:0] len, input int cycles);
        @(posedge clk); #1;
        req = 1'b1; rnw = r; reg_adr = ra; wr_data = wd; rd_len = len;
        repeat (cycles) @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({name, " done seen"}, 32'(got), 32'd1);
    endtask

    task automatic chk_rd(input logic [4:0] idx, input logic [7:0] expv);
        rd_idx = idx;
        #1 check($sformatf("rd_data[%0d]", idx), 32'(rd_data), 32'(expv));
    endtask

    // Behavioural master: consumes a byte 20 send-cycles after it appears, returns
    // queued bytes 4 receive-cycles apart; each strobe is held high for 2 cycles.
    initial begin
        int m_cnt = 0;
        int m_hold = 0;
        forever begin
            @(posedge clk); #1;
            if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) begin
                    sended = 1'b0;
                    received = 1'b0;
                end
            end else if (send) begin
                m_cnt++;
                if (m_cnt == 20) begin
                    sended = 1'b1; m_hold = 2; m_cnt = 0;
                end
            end else if (receive && rx_q.size() > 0) begin
                m_cnt++;
                if (m_cnt == 4) begin
                    datareceive = rx_q.pop_front();
                    received = 1'b1; m_hold = 2; m_cnt = 0;
                    last_rx_cyc = cyc + 1;
                end
            end else begin
                m_cnt = 0;
            end
        end
    end

    // Monitor: a byte is presented when the master first raises sended; done is a pulse.
    logic sended_prev = 1'b0;
    int   st_cnt = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset) begin
            st_cnt = 0;
        end else begin
            if (start) st_cnt++;
            if (receive) rx_hi++;
            if (sended && !sended_prev) begin
                check("scoreboard entry for byte", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("kind is byte", 32'(mon_e.is_done), 32'd0);
                    check("datasend", 32'(datasend), 32'(mon_e.val));
                    check("start cycles", 32'(st_cnt), 32'(mon_e.st));
                end
                st_cnt = 0;
            end
            if (done) begin
                check("scoreboard entry for done", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("kind is done", 32'(mon_e.is_done), 32'd1);
                    check("err", 32'(err), 32'(mon_e.err));
                end
                st_cnt = 0;
            end
        end
        sended_prev = sended;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        reset = 1'b1; req = 1'b0; rnw = 1'b0; reg_adr = 8'h00; wr_data = 8'h00;
        rd_len = 5'd0; rd_idx = 5'd0; isReady = 1'b1; sended = 1'b0; received = 1'b0;
        datareceive = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset send/start/receive", 32'({send, start, receive}), 0);
        check("reset datasend", 32'(datasend), 0);
        chk_rd(5'd0, 8'h00);

        // Single-byte read
        exp_byte(8'hEE, 15); exp_byte(8'hD0, 0); exp_byte(8'hEF, 15); exp_done(1'b0);
        rx_q.push_back(8'h55);
        do_req(1'b1, 8'hD0, 8'h00, 5'd1, 1);
        @(negedge clk);
        check("busy after accept", 32'(busy), 1);
        wait_done("read1", 2000);
        check("busy low in done cycle", 32'(busy), 0);
        @(negedge clk);
        check("done is one cycle", 32'(done), 0);
        chk_rd(5'd0, 8'h55);

        // Full-length burst read
        exp_byte(8'hEE, 15); exp_byte(8'hAA, 0); exp_byte(8'hEF, 15); exp_done(1'b0);
        for (int i = 0; i < 22; i++) rx_q.push_back(8'(i));
        do_req(1'b1, 8'hAA, 8'h00, 5'd22, 1);
        wait_done("burst", 4000);
        for (int i = 0; i < 22; i++) chk_rd(5'(i), 8'(i));
        chk_rd(5'd22, 8'h00);
        chk_rd(5'd31, 8'h00);

        // Register write
        rx_hi = 0;
        exp_byte(8'hEE, 15); exp_byte(8'hF4, 0); exp_byte(8'h2E, 0); exp_done(1'b0);
        do_req(1'b0, 8'hF4, 8'h2E, 5'd0, 1);
        wait_done("write", 2000);
        check("receive during write", 32'(rx_hi), 0);
        chk_rd(5'd0, 8'h00);
        chk_rd(5'd5, 8'h05);
        chk_rd(5'd21, 8'h15);

        // Bad lengths: done+err the cycle after req, no bus activity
        for (int t = 0; t < 2; t++) begin
            exp_done(1'b1);
            do_req(1'b1, 8'h10, 8'h00, (t == 0) ? 5'd0 : 5'd23, 1);
            @(negedge clk);
            check($sformatf("badlen%0d done", t), 32'(done), 1);
            check($sformatf("badlen%0d err", t), 32'(err), 1);
            acc = 1'b0;
            repeat (5) begin
                @(negedge clk);
                acc = acc | send | start | busy;
            end
            check($sformatf("badlen%0d quiet bus", t), 32'(acc), 0);
        end
        // req held into the done cycle: second sample must be ignored
        exp_done(1'b1);
        do_req(1'b1, 8'h10, 8'h00, 5'd23, 2);
        repeat (10) @(negedge clk);

        // Timeout after two of four bytes
        exp_byte(8'hEE, 15); exp_byte(8'h10, 0); exp_byte(8'hEF, 15); exp_done(1'b1);
        rx_q.push_back(8'hA1); rx_q.push_back(8'hA2);
        do_req(1'b1, 8'h10, 8'h00, 5'd4, 1);
        wait_done("timeout", 3000);
        check("timeout latency", 32'(cyc - last_rx_cyc), 32'(TMO));
        chk_rd(5'd0, 8'hA1);
        chk_rd(5'd1, 8'hA2);
        chk_rd(5'd2, 8'h02);
        chk_rd(5'd3, 8'h03);

        // req while busy is ignored
        exp_byte(8'hEE, 15); exp_byte(8'h20, 0); exp_byte(8'h33, 0); exp_done(1'b0);
        do_req(1'b0, 8'h20, 8'h33, 5'd0, 1);
        repeat (10) @(posedge clk);
        do_req(1'b1, 8'h40, 8'h00, 5'd1, 1);
        wait_done("busy ignore", 2000);
        repeat (80) @(negedge clk);

        // Reset in the middle of SEND: no done, outputs idle
        do_req(1'b0, 8'hF4, 8'h2E, 5'd0, 1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post-reset busy", 32'(busy), 0);
        check("post-reset send/start/receive", 32'({send, start, receive}), 0);
        check("post-reset done", 32'(done), 0);
        check("post-reset datasend", 32'(datasend), 0);
        repeat (60) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
- Parametrised I2C register-transaction sequencer for sensor front-ends such as BMP180.
- Sits between control logic and the existing byte-level I2C master, using the same master handshake (isReady/start/send/sended/receive/received).
- Runs one of two transaction types per request:
  - burst read: write register pointer, repeated start, read N bytes into an internal buffer;
  - single-byte register write: for example, setting a measurement mode.
- Adds timeout/error reporting and a random-access readout port for the captured bytes.

Parameters:
- DEV_ADR, 7'h77, 7-bit I2C device address.
- MAX_BYTES, 22, read buffer depth in bytes; maximum burst length.
- CNT_W, 5, width of length/index ports; MAX_BYTES < 2**CNT_W is required.
- START_HOLD, 15, clk cycles that start is held high at the beginning of a start-flagged byte.
- TIMEOUT, 65535, clk cycles to wait for any master edge before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  one-cycle request, sampled only in IDLE.
- rnw  in  1  1 = burst read, 0 = single-byte write; sampled with req.
- reg_adr  in  8  register address; sampled with req.
- wr_data  in  8  write payload; sampled with req.
- rd_len  in  CNT_W  number of bytes to read; sampled with req.
- busy  out  1  high from the cycle after an accepted req until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid while done=1: 1 = bad length or timeout.
- rd_idx  in  CNT_W  buffer read index.
- rd_data  out  8  combinational buf[rd_idx]; 8'h00 if rd_idx >= MAX_BYTES.
- isReady  in  1  master idle.
- start  out  1  generate START/RESTART for the current byte.
- send  out  1  master may transmit datasend.
- datasend  out  8  current byte to transmit.
- sended  in  1  master byte-sent indicator; rising edge = byte consumed.
- receive  out  1  master may receive the next byte.
- datareceive  in  8  received byte.
- received  in  1  rising edge = datareceive valid.

Behaviour:
- Reset:
  - busy/done/err/start/send/receive = 0; datasend = 8'h00.
  - FSM goes to IDLE; all buffer entries and edge-detect registers are cleared.
  - Reset mid-transaction abandons it with no done pulse; outputs are 0 on the next cycle.
- Edge detection: sended and received are registered each cycle; a rising edge is (cur & ~prev).
- Byte list, frozen at req acceptance:
  - B0 = {S=1, DEV_ADR, W=0}
  - B1 = {S=0, reg_adr}
  - Read: B2 = {S=1, DEV_ADR, R=1}
  - Write: B2 = {S=0, wr_data}
- IDLE:
  - req=1, and either rnw=0 or rd_len in 1..MAX_BYTES: latch inputs, set busy, go to WAIT_RDY.
  - req=1, rnw=1, rd_len=0 or rd_len>MAX_BYTES: done=1, err=1 the next cycle, no bus activity, stay in IDLE.
  - req=0: stay in IDLE.
- WAIT_RDY: on isReady=1, set byte index k=0 and go to SEND.
- SEND:
  - datasend = Bk[7:0]; send = 1.
  - If Bk has S=1, start=1 for the first START_HOLD cycles of this state, then 0.
  - On a sended rising edge: k=k+1.
    - k<3: stay in SEND with the new byte; the start hold counter reloads.
    - k=3, read: go to RECV with j=0.
    - k=3, write: go to FIN.
- RECV:
  - send=0, receive=1, datasend=8'h00.
  - On a received rising edge: buf[j] <= datareceive, j=j+1.
  - When j reaches rd_len: go to FIN. receive drops in the same cycle as the capture of the last byte.
- FIN: busy=0, done=1, err=0 for one cycle; then IDLE.
- Timeout:
  - A counter reloads on each state entry and on each accepted edge in WAIT_RDY/SEND/RECV.
  - Reaching TIMEOUT: drop send/receive/start, pulse done=1 with err=1, go to IDLE.
  - On a timeout, bytes captured so far stay in the buffer.
- Buffer contents:
  - Buffer entries at index >= rd_len keep their previous values.
  - A write transaction never modifies the buffer.
- Request handling: req while busy is ignored. A req in the same cycle as done is ignored; a new req is accepted from the cycle after done.
- Edge coincidence: a sended edge during RECV and a received edge during SEND are ignored.

Test Plan:
- Reset, then read: req with rnw=1, reg_adr=8'hD0, rd_len=1; master returns 8'h55 -> datasend sequence EE, D0, EF; start high 15 cycles on EE and EF only; buf[0]=55; done=1, err=0; rd_data(idx 0)=55.
- Burst read rd_len=22, reg_adr=8'hAA, master returns 8'h00..8'h15 -> buf[k]=k for all k; rd_data(idx 22)=00; exactly one done pulse.
- Write: rnw=0, reg_adr=8'hF4, wr_data=8'h2E -> datasend EE, F4, 2E; receive never asserted; done, err=0; buffer unchanged.
- Bad length: rd_len=0, then rd_len=23 -> each gives done=1, err=1 one cycle after req; send/start stay 0.
- Timeout: TIMEOUT=100; master stops after 2 received edges of a rd_len=4 read -> done=1, err=1 exactly 100 cycles after the last edge; buf[0..1] updated, buf[2..3] unchanged.
- Reset asserted mid-SEND, and a second req while busy -> outputs 0 the cycle after reset with no done pulse; the ignored req causes no second transaction.
